shift_pipe_ctrl: RTL and testbench

SHIFT_PIPE_CTRL -- requirements
Module: shift_pipe_ctrl

---
 rtl/shift_pipe_ctrl.sv | 112 +++++++++++
 tb/tb_shift_pipe_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe_ctrl.sv
// Four-stage left shifter with valid/ready flow control and collapsing bubbles.
// Optional feature macro SHIFT_ROT_EN adds a per-request rotate-left mode (in_rot).
module shift_pipe_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_amt,
`ifdef SHIFT_ROT_EN
  input  logic             in_rot,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [2:0]       occ
);

  logic [3:0]            valid_reg;
  logic [3:0][WIDTH-1:0] data_reg;
  // Remaining shift-amount bits still to be applied downstream of each stage
  logic [2:0]            rem1_reg;
  logic [1:0]            rem2_reg;
  logic                  rem3_reg;

  logic [3:0]            hold;
  logic [3:0]            src_valid;
  logic [3:0]            load;
  logic [3:0][WIDTH-1:0] src_data;
  logic [3:0][WIDTH-1:0] data_next;
  logic [3:0]            shift_en;
  logic [3:0]            rot_en;

`ifdef SHIFT_ROT_EN
  logic [2:0] rot_reg;
  assign rot_en = {rot_reg, in_rot};
`else
  assign rot_en = '0;
`endif

  // Back-pressure ripples from the output: a stage stalls only if everything after it is stalled
  always_comb begin
    hold    = '0;
    hold[3] = valid_reg[3] & ~out_ready;
    for (int i = 2; i >= 0; i--) begin
      hold[i] = valid_reg[i] & hold[i+1];
    end
  end

  assign in_ready  = ~hold[0];
  assign src_valid = {valid_reg[2:0], in_valid};
  assign src_data  = {data_reg[2:0], in_data};
  assign shift_en  = {rem3_reg, rem2_reg[0], rem1_reg[0], in_amt[0]};
  assign load      = ~hold & src_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      logic [WIDTH-1:0] zf;
      logic [WIDTH-1:0] rl;
      assign zf = src_data[gi] << SH;
      assign rl = zf | (src_data[gi] >> (WIDTH - SH));
      assign data_next[gi] = !shift_en[gi] ? src_data[gi] : (rot_en[gi] ? rl : zf);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= '0;
      data_reg  <= '0;
      rem1_reg  <= '0;
      rem2_reg  <= '0;
      rem3_reg  <= 1'b0;
`ifdef SHIFT_ROT_EN
      rot_reg   <= '0;
`endif
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!hold[i]) begin
          valid_reg[i] <= src_valid[i];
        end
        if (load[i]) begin
          data_reg[i] <= data_next[i];
        end
      end
      if (load[0]) rem1_reg <= in_amt[3:1];
      if (load[1]) rem2_reg <= rem1_reg[2:1];
      if (load[2]) rem3_reg <= rem2_reg[1];
`ifdef SHIFT_ROT_EN
      if (load[0]) rot_reg[0] <= in_rot;
      if (load[1]) rot_reg[1] <= rot_reg[0];
      if (load[2]) rot_reg[2] <= rot_reg[1];
`endif
    end
  end

  assign out_valid = valid_reg[3];
  assign out_data  = data_reg[3];
  assign busy      = |valid_reg;

  always_comb begin
    occ = '0;
    for (int i = 0; i < 4; i++) begin
      occ = occ + 3'(valid_reg[i]);
    end
  end

endmodule

// File: tb/tb_shift_pipe_ctrl.sv
// Directed self-checking bench for shift_pipe_ctrl; expected values are hand-computed.
// Build with +define+SHIFT_ROT_EN to exercise the rotate variant.
module tb_shift_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic        in_rot;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic [2:0]  occ;

  int checks = 0;
  int errors = 0;

  shift_pipe_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
`ifdef SHIFT_ROT_EN
    .in_rot    (in_rot),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .occ       (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int max_cycles);
    int n;
    n = 0;
    while (!out_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  logic [15:0] exp_seq [4];
  logic [15:0] exp_rot;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_rot    = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_occ",       32'(occ),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // Single request 0x0001 << 5, four-edge latency
    in_valid = 1'b1; in_data = 16'h0001; in_amt = 4'd5;
    tick();
    in_valid = 1'b0;
    check("single_occ1",  32'(occ),  32'd1);
    check("single_busy",  32'(busy), 32'd1);
    tick();
    tick();
    check("single_not_yet", 32'(out_valid), 32'd0);
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data",  32'(out_data),  32'h0020);
    tick();
    check("single_drained", 32'(out_valid), 32'd0);
    check("single_occ0",    32'(occ),       32'd0);

    // Back-to-back amounts 0..3 on 0xFFFF
    exp_seq[0] = 16'hFFFF; exp_seq[1] = 16'hFFFE;
    exp_seq[2] = 16'hFFFC; exp_seq[3] = 16'hFFF8;
    in_data = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_amt = 4'(k);
      #1;
      check($sformatf("b2b_in_ready%0d", k), 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b2b_valid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("b2b_data%0d", k),  32'(out_data),  32'(exp_seq[k]));
      tick();
    end
    check("b2b_empty", 32'(out_valid), 32'd0);

    // Back-pressure: 3 << k, k = 0..4, with out_ready low
    out_ready = 1'b0;
    in_data   = 16'h0003;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_amt = 4'(k);
      #1;
      check($sformatf("bp_in_ready%0d", k), 32'(in_ready), 32'd1);
      tick();
    end
    in_amt = 4'd4;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("bp_full_in_ready%0d", k), 32'(in_ready), 32'd0);
      check($sformatf("bp_full_occ%0d", k),      32'(occ),      32'd4);
      check($sformatf("bp_hold_data%0d", k),     32'(out_data), 32'h0003);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_accept_on_drain", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_drain1", 32'(out_data), 32'h0006);
    tick();
    check("bp_drain2", 32'(out_data), 32'h000C);
    tick();
    check("bp_drain3", 32'(out_data), 32'h0018);
    tick();
    check("bp_drain4_valid", 32'(out_valid), 32'd1);
    check("bp_drain4", 32'(out_data), 32'h0030);
    tick();
    check("bp_empty_occ", 32'(occ), 32'd0);

    // Reset mid-flight with three items in the pipe
    in_data = 16'h1234; in_amt = 4'd1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("mid_occ3", 32'(occ), 32'd3);
    rst_n = 1'b0;
    tick();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_occ",       32'(occ),       32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("mid_no_stale%0d", k), 32'(out_valid), 32'd0);
    end

    // Amount 15 boundary: zero-fill and (optionally) rotate
    in_valid = 1'b1; in_data = 16'h0001; in_amt = 4'd15; in_rot = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_out(8);
    check("amt15_zero_fill", 32'(out_data), 32'h8000);
    tick();

`ifdef SHIFT_ROT_EN
    exp_rot = 16'hC000;
`else
    exp_rot = 16'h8000;
`endif
    in_valid = 1'b1; in_data = 16'h8001; in_amt = 4'd15; in_rot = 1'b1;
    tick();
    in_valid = 1'b0; in_rot = 1'b0;
    wait_out(8);
    check("amt15_8001", 32'(out_data), 32'(exp_rot));
    tick();
    check("final_occ", 32'(occ), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
